draw_region_blit: RTL and testbench
===================================

// Module: draw_region_blit
// PURPOSE
//  Parametrised rectangle painter feeding the VGA adapter (x, y, colour, plot). On start, walks a
//  WxH region at (x0,y0) row-major, one pixel per clock, sourcing colour either from a
//  constant or from a background ROM at the same screen coordinate (region restore).
//  Replaces whole-screen-only clear logic. Used to erase and redraw sprites without a full-frame wipe.
// PARAMETERS
//  SCREEN_W    160  screen width in pixels; also the ROM row stride
//  SCREEN_H    120  screen height in pixels
//  X_W         8    x coordinate / width bus width
//  Y_W         7    y coordinate / height bus width
//  COLOUR_W    3    colour width
//  ADDR_W      15   ROM address width (>= clog2(SCREEN_W*SCREEN_H))
//  ROM_LAT     1    ROM read latency in clocks (0..3)
//  TRANSP_KEY  3'b000  colour treated as transparent (used only with the macro)
// PORTS
//  clock        in   1         system clock, rising edge
//  reset        in   1         asynchronous, active-high
//  start        in   1         one-cycle request, sampled only in IDLE
//  x0, y0       in   X_W/Y_W   region origin, latched on accepted start
//  width        in   X_W       region width in pixels, latched
//  height       in   Y_W       region height in pixels, latched
//  use_rom      in   1         1 = ROM colour, 0 = fill_colour; latched
//  fill_colour  in   COLOUR_W  constant colour, latched
//  rom_address  out  ADDR_W    ROM read address
//  rom_q        in   COLOUR_W  ROM data, valid ROM_LAT clocks after address
//  vga_x, vga_y out  X_W/Y_W   pixel coordinate
//  colour       out  COLOUR_W  pixel colour
//  plot         out  1         write enable; x/y/colour valid when high
//  busy         out  1         high from accepted start until done
//  done         out  1         one-cycle pulse after the last plot
// BEHAVIOUR
//  - Reset (async): state IDLE; all counters 0; vga_x, vga_y, colour, rom_address = 0; plot, busy, done = 0.
//  - FSM: IDLE -start&width!=0&height!=0-> RUN; IDLE -start&(width==0|height==0)-> DONE;
//    RUN -last pixel issued-> FLUSH; FLUSH -ROM_LAT clocks elapsed-> DONE; DONE -> IDLE (1 cycle).
//  - start while not IDLE is ignored; inputs are not re-sampled until IDLE.
//  - RUN issues one pixel/clock: col 0..width-1 inner, row 0..height-1 outer; no idle gap at row wrap.
//  - Issued coordinate: px = x0+col, py = y0+row, computed at X_W+1 / Y_W+1 bits (no wrap).
//  - rom_address = py*SCREEN_W + px, truncated to ADDR_W, driven in the issue cycle.
//  - Output stage: px, py, in-screen flag and latched fill_colour delayed ROM_LAT clocks,
//    so vga_x/vga_y/colour/plot are aligned with rom_q; total latency start->first plot = 1+ROM_LAT.
//  - Clipping: pixel with px>=SCREEN_W or py>=SCREEN_H still consumes its cycle, but plot=0.
//  - plot is registered; vga_x/vga_y/colour hold their last values when plot=0.
//  - busy = (state != IDLE); done pulses in DONE state exactly once per accepted start.
//  - ROM_LAT=0: rom_q used combinationally in the issue cycle; FLUSH lasts 0 cycles.
//  - Reset mid-operation aborts immediately; no done pulse is produced for the aborted job.
// CONFIGURATION
//  DRAW_REGION_TRANSPARENT_EN defined: in ROM mode, a pixel whose rom_q == TRANSP_KEY has
//    plot forced to 0 (cycle still consumed); fill mode is unaffected.
//  Not defined: every in-screen pixel is plotted regardless of colour; TRANSP_KEY unused.
// TESTING
//  1. Defaults, reset, start x0=10 y0=20 w=4 h=2 use_rom=0 fill=3'b101 -> 8 plots
//     (10..13,20),(10..13,21), colour 101, first plot 2 clocks after start, done 1 cycle after last plot.
//  2. use_rom=1, ROM model data = address[2:0], region (159,119) 1x1 -> rom_address 19199,
//     one plot at (159,119) with colour 3'b111.
//  3. x0=158 y0=118 w=4 h=4 -> 16 issue cycles, plot only for (158..159,118..119) = 4 plots; done once.
//  4. width=0 -> no plot, busy high 1 cycle, done 1 cycle after start; second start during RUN -> ignored.
//  5. Assert reset mid-RUN of 8x8 job -> plot, busy, done go 0 asynchronously; fresh start after
//     release completes normally with 64 plots; repeat with ROM_LAT=2 checking alignment.
//  6. With DRAW_REGION_TRANSPARENT_EN, ROM returns 000 at even px -> only odd-px pixels plotted;
//     without macro all pixels plotted.

Source files
------------

// File: rtl/draw_region_blit.sv
// draw_region_blit: paints a WxH screen region row-major, one pixel per clock, from a
// constant colour or from the background ROM at the same coordinate (region restore).
// Optional feature macro: DRAW_REGION_TRANSPARENT_EN (ROM pixels equal to TRANSP_KEY are not plotted).
module draw_region_blit #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W = 8,
  parameter int Y_W = 7,
  parameter int COLOUR_W = 3,
  parameter int ADDR_W = 15,
  parameter int ROM_LAT = 1,
  parameter logic [COLOUR_W-1:0] TRANSP_KEY = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic [X_W-1:0]      x0,
  input  logic [Y_W-1:0]      y0,
  input  logic [X_W-1:0]      width,
  input  logic [Y_W-1:0]      height,
  input  logic                use_rom,
  input  logic [COLOUR_W-1:0] fill_colour,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [COLOUR_W-1:0] rom_q,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done
);
`ifdef DRAW_REGION_TRANSPARENT_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif
  localparam int PW = 1 + X_W + Y_W + COLOUR_W;
  localparam logic [X_W:0] SW = SCREEN_W[X_W:0];
  localparam logic [Y_W:0] SH = SCREEN_H[Y_W:0];
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;
  state_t state_q, state_d;
  logic [X_W-1:0] x0_q, x0_d, w_q, w_d, col_q, col_d, vga_x_q, vga_x_d;
  logic [Y_W-1:0] y0_q, y0_d, h_q, h_d, row_q, row_d, vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] fill_q, fill_d, colour_q, colour_d;
  logic ur_q, ur_d, plot_q, plot_d, busy_q, busy_d, done_q, done_d;
  logic [1:0] fl_q, fl_d;
  logic [X_W:0] px;
  logic [Y_W:0] py;
  logic issue, in_scr, last, keyed;
  logic [PW-1:0] stage_d, tail;
  logic t_vld;
  logic [X_W-1:0] t_x;
  logic [Y_W-1:0] t_y;
  logic [COLOUR_W-1:0] t_fill, pix_colour;
  // Issue side: current pixel coordinate, clip flag and ROM address, widened so nothing wraps
  always_comb begin
    issue = state_q == RUN;
    px = {1'b0, x0_q} + {1'b0, col_q};
    py = {1'b0, y0_q} + {1'b0, row_q};
    in_scr = (px < SW) && (py < SH);
    rom_address = issue ? ADDR_W'(32'(py) * 32'(SCREEN_W) + 32'(px)) : '0;
    stage_d = {issue & in_scr, px[X_W-1:0], py[Y_W-1:0], fill_q};
    last = (col_q == w_q - X_W'(1)) && (row_q == h_q - Y_W'(1));
  end
  // Control FSM next state: latch the job on start, walk col/row, drain the ROM pipeline
  always_comb begin
    state_d = state_q;
    x0_d = x0_q;
    y0_d = y0_q;
    w_d = w_q;
    h_d = h_q;
    ur_d = ur_q;
    fill_d = fill_q;
    col_d = col_q;
    row_d = row_q;
    fl_d = fl_q;
    case (state_q)
      IDLE: if (start) begin
        x0_d = x0;
        y0_d = y0;
        w_d = width;
        h_d = height;
        ur_d = use_rom;
        fill_d = fill_colour;
        col_d = '0;
        row_d = '0;
        state_d = (width == '0 || height == '0) ? DONE : RUN;
      end
      RUN: begin
        col_d = (col_q == w_q - X_W'(1)) ? '0 : col_q + X_W'(1);
        row_d = (col_q == w_q - X_W'(1)) ? row_q + Y_W'(1) : row_q;
        fl_d = '0;
        if (last) state_d = (ROM_LAT == 0) ? DONE : FLUSH;
      end
      FLUSH: begin
        fl_d = fl_q + 2'd1;
        if (fl_q == 2'(ROM_LAT - 1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    // done lags the DONE state by one clock so it lands one cycle after the final plot
    done_d = state_q == DONE;
  end
  // ROM_LAT-deep delay of the issue-side pixel so it meets rom_q at the output stage
  generate
    if (ROM_LAT == 0) begin : g_nolat
      assign tail = stage_d;
    end else begin : g_lat
      logic [PW-1:0] pipe_q [ROM_LAT];
      // Shift register aligning coordinates, clip flag and fill colour with the ROM read
      always_ff @(posedge clock or posedge reset)
        if (reset) for (int i = 0; i < ROM_LAT; i++) pipe_q[i] <= '0;
        else begin
          pipe_q[0] <= stage_d;
          for (int i = 1; i < ROM_LAT; i++) pipe_q[i] <= pipe_q[i-1];
        end
      assign tail = pipe_q[ROM_LAT-1];
    end
  endgenerate
  // Output stage: pick the colour source, suppress keyed pixels, hold x/y/colour when idle
  always_comb begin
    {t_vld, t_x, t_y, t_fill} = tail;
    pix_colour = ur_q ? rom_q : t_fill;
    keyed = TRANSP_EN && ur_q && (rom_q == TRANSP_KEY);
    plot_d = t_vld & ~keyed;
    vga_x_d = plot_d ? t_x : vga_x_q;
    vga_y_d = plot_d ? t_y : vga_y_q;
    colour_d = plot_d ? pix_colour : colour_q;
  end
  // All FSM state, job registers and registered outputs
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      x0_q <= '0;
      y0_q <= '0;
      w_q <= '0;
      h_q <= '0;
      ur_q <= 1'b0;
      fill_q <= '0;
      col_q <= '0;
      row_q <= '0;
      fl_q <= '0;
      vga_x_q <= '0;
      vga_y_q <= '0;
      colour_q <= '0;
      plot_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q <= x0_d;
      y0_q <= y0_d;
      w_q <= w_d;
      h_q <= h_d;
      ur_q <= ur_d;
      fill_q <= fill_d;
      col_q <= col_d;
      row_q <= row_d;
      fl_q <= fl_d;
      vga_x_q <= vga_x_d;
      vga_y_q <= vga_y_d;
      colour_q <= colour_d;
      plot_q <= plot_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  assign vga_x = vga_x_q;
  assign vga_y = vga_y_q;
  assign colour = colour_q;
  assign plot = plot_q;
  assign busy = busy_q;
  assign done = done_q;
endmodule

// File: tb/tb_draw_region_blit.sv
// tb_draw_region_blit: two instances (ROM_LAT 1 and 2) checked every cycle against a job-level model.
module tb_draw_region_blit;
  logic clk = 0, rst = 0, start = 0, use_rom = 0;
  logic [7:0] x0 = 0, width = 0;
  logic [6:0] y0 = 0, height = 0;
  logic [2:0] fill = 0;
  int rom_mode = 0;
  logic [14:0] ra1, ra2;
  logic [2:0] rq1, rq2, r2a, c1, c2;
  logic [7:0] vx1, vx2;
  logic [6:0] vy1, vy2;
  logic p1, p2, b1, b2, d1, d2;
  int tests = 0, fails = 0;
  int cyc = 0;
  bit jv [2];
  bit jur [2];
  int n0 [2], jx [2], jy [2], jw [2], jh [2], jf [2];
  int lx [2], ly [2], lc [2];
  int pc [2], dc [2];
  always #5 clk = ~clk;
  draw_region_blit #(.ROM_LAT(1)) u1 (.clock(clk), .reset(rst), .start(start), .x0(x0), .y0(y0),
    .width(width), .height(height), .use_rom(use_rom), .fill_colour(fill), .rom_address(ra1),
    .rom_q(rq1), .vga_x(vx1), .vga_y(vy1), .colour(c1), .plot(p1), .busy(b1), .done(d1));
  draw_region_blit #(.ROM_LAT(2)) u2 (.clock(clk), .reset(rst), .start(start), .x0(x0), .y0(y0),
    .width(width), .height(height), .use_rom(use_rom), .fill_colour(fill), .rom_address(ra2),
    .rom_q(rq2), .vga_x(vx2), .vga_y(vy2), .colour(c2), .plot(p2), .busy(b2), .done(d2));
  function automatic logic [2:0] romf(input logic [14:0] a);
    return rom_mode == 0 ? a[2:0] : (a[0] ? 3'b110 : 3'b000);
  endfunction
  always @(posedge clk) begin
    rq1 <= romf(ra1);
    r2a <= romf(ra2);
    rq2 <= r2a;
  end
  // last busy cycle offset from the accepting edge: N pixels plus ROM latency, or 0 for an empty job
  function automatic int jend(input int i);
    return (jw[i] * jh[i] == 0) ? 0 : jw[i] * jh[i] + i + 1;
  endfunction
  always @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 2; i++) jv[i] <= 0;
    else begin
      int e;
      e = cyc + 1;
      cyc <= e;
      for (int i = 0; i < 2; i++)
        if (start && (!jv[i] || e - n0[i] >= jend(i) + 2)) begin
          jv[i] <= 1;
          n0[i] <= e;
          jx[i] <= int'(x0);
          jy[i] <= int'(y0);
          jw[i] <= int'(width);
          jh[i] <= int'(height);
          jur[i] <= use_rom;
          jf[i] <= int'(fill);
        end
    end
  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask
  task automatic cmp(input int i, input logic p, input logic b, input logic dn, input logic [7:0] vx,
                     input logic [6:0] vy, input logic [2:0] c, input logic [14:0] ra);
    int d, n, k, px, py, col;
    bit ep;
    string t;
    t = $sformatf("L%0d", i + 1);
    ep = 0;
    if (rst || !jv[i]) begin
      if (rst) begin
        lx[i] = 0;
        ly[i] = 0;
        lc[i] = 0;
      end
      chk({t, " busy"}, int'(b), 0);
      chk({t, " done"}, int'(dn), 0);
    end else begin
      n = jw[i] * jh[i];
      d = cyc - n0[i];
      chk({t, " busy"}, int'(b), int'(d <= jend(i)));
      chk({t, " done"}, int'(dn), int'(d == jend(i) + 1));
      if (n > 0 && d >= 0 && d < n)
        chk({t, " rom_address"}, int'(ra), ((jy[i] + d / jw[i]) * 160 + jx[i] + d % jw[i]) % 32768);
      if (n > 0 && d >= i + 2 && d <= n + i + 1) begin
        k = d - i - 2;
        px = jx[i] + k % jw[i];
        py = jy[i] + k / jw[i];
        col = jur[i] ? int'(romf(15'(py * 160 + px))) : jf[i];
        ep = px < 160 && py < 120;
`ifdef DRAW_REGION_TRANSPARENT_EN
        if (jur[i] && col == 0) ep = 0;
`endif
        if (ep) begin
          lx[i] = px;
          ly[i] = py;
          lc[i] = col;
        end
      end
    end
    chk({t, " plot"}, int'(p), int'(ep));
    chk({t, " vga_x"}, int'(vx), lx[i]);
    chk({t, " vga_y"}, int'(vy), ly[i]);
    chk({t, " colour"}, int'(c), lc[i]);
    if (p) pc[i]++;
    if (dn) dc[i]++;
  endtask
  always @(negedge clk) begin
    cmp(0, p1, b1, d1, vx1, vy1, c1, ra1);
    cmp(1, p2, b2, d2, vx2, vy2, c2, ra2);
  end
  task automatic go(input int x, input int y, input int w, input int h, input logic ur, input int f);
    @(posedge clk);
    #2;
    x0 = 8'(x);
    y0 = 7'(y);
    width = 8'(w);
    height = 7'(h);
    use_rom = ur;
    fill = 3'(f);
    start = 1;
    @(posedge clk);
    #2;
    start = 0;
  endtask
  task automatic settle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1;
  endtask
  initial begin
    int a0, a1, e0, e1;
    #1 rst = 1;
    #20;
    chk("reset plot", int'(p1 | p2), 0);
    chk("reset busy", int'(b1 | b2), 0);
    chk("reset done", int'(d1 | d2), 0);
    chk("reset xy", int'(vx1) + int'(vy1) + int'(vx2) + int'(vy2), 0);
    chk("reset colour/addr", int'(c1) + int'(c2) + int'(ra1) + int'(ra2), 0);
    @(negedge clk) rst = 0;
    // 4x2 fill at (10,20): first plot two clocks after the accepting edge
    a0 = pc[0]; a1 = pc[1]; e0 = dc[0]; e1 = dc[1];
    go(10, 20, 4, 2, 0, 5);
    @(posedge clk) #3 chk("t1 early plot", int'(p1), 0);
    @(posedge clk) #3 begin
      chk("t1 first plot", int'(p1), 1);
      chk("t1 first x", int'(vx1), 10);
      chk("t1 first y", int'(vy1), 20);
      chk("t1 first colour", int'(c1), 5);
    end
    settle(12);
    chk("t1 plots L1", pc[0] - a0, 8);
    chk("t1 plots L2", pc[1] - a1, 8);
    chk("t1 dones", (dc[0] - e0) * 10 + dc[1] - e1, 11);
    // 1x1 ROM restore at the bottom-right corner
    a0 = pc[0]; a1 = pc[1];
    go(159, 119, 1, 1, 1, 0);
    #1 chk("t2 rom_address", int'(ra1), 19199);
    chk("t2 rom_address L2", int'(ra2), 19199);
    @(posedge clk);
    @(posedge clk) #3 begin
      chk("t2 plot", int'(p1), 1);
      chk("t2 x", int'(vx1), 159);
      chk("t2 y", int'(vy1), 119);
      chk("t2 colour", int'(c1), 7);
    end
    settle(6);
    chk("t2 plots", (pc[0] - a0) * 10 + pc[1] - a1, 11);
    // 4x4 region straddling the bottom-right screen edge
    a0 = pc[0]; a1 = pc[1]; e0 = dc[0]; e1 = dc[1];
    go(158, 118, 4, 4, 0, 3);
    settle(20);
    chk("t3 plots L1", pc[0] - a0, 4);
    chk("t3 plots L2", pc[1] - a1, 4);
    chk("t3 dones", (dc[0] - e0) * 10 + dc[1] - e1, 11);
    // zero-width job, then a start during RUN that must be ignored
    a0 = pc[0]; a1 = pc[1]; e0 = dc[0]; e1 = dc[1];
    go(30, 40, 0, 5, 0, 1);
    #1 chk("t4 busy", int'(b1), 1);
    chk("t4 no done yet", int'(d1), 0);
    @(posedge clk) #3 begin
      chk("t4 busy drop", int'(b1), 0);
      chk("t4 done", int'(d1), 1);
    end
    settle(4);
    go(5, 5, 4, 2, 0, 2);
    repeat (2) @(posedge clk);
    go(50, 50, 4, 4, 0, 6);
    settle(16);
    chk("t4 plots L1", pc[0] - a0, 8);
    chk("t4 plots L2", pc[1] - a1, 8);
    chk("t4 dones", (dc[0] - e0) * 10 + dc[1] - e1, 22);
    // abort an 8x8 job with reset, then run a fresh ROM job to completion
    a0 = pc[0]; a1 = pc[1]; e0 = dc[0]; e1 = dc[1];
    go(0, 0, 8, 8, 0, 4);
    repeat (10) @(posedge clk);
    #2 rst = 1;
    #1 begin
      chk("t5 async plot", int'(p1 | p2), 0);
      chk("t5 async busy", int'(b1 | b2), 0);
      chk("t5 async done", int'(d1 | d2), 0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 0;
    a0 = pc[0]; a1 = pc[1];
    go(0, 0, 8, 8, 1, 0);
    settle(70);
    chk("t5 plots L1", pc[0] - a0, 64);
    chk("t5 plots L2", pc[1] - a1, 64);
    chk("t5 dones", (dc[0] - e0) * 10 + dc[1] - e1, 11);
    // ROM returning 000 at even px
    rom_mode = 1;
    a0 = pc[0]; a1 = pc[1];
    go(20, 30, 6, 2, 1, 7);
    settle(16);
`ifdef DRAW_REGION_TRANSPARENT_EN
    chk("t6 plots", (pc[0] - a0) * 100 + pc[1] - a1, 606);
`else
    chk("t6 plots", (pc[0] - a0) * 100 + pc[1] - a1, 1212);
`endif
    rom_mode = 0;
    settle(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
